// File: rtl/ddr2_burst_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_burst_if
// Description : Burst-level handshake between a user-side traffic source and
//               the DDR2 controller: write request/address/length/data with
//               data-request and finish strobes, and the matching read side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr2_burst_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  // Write channel
  logic                  wr_burst_req;
  logic [ADDR_WIDTH-1:0] wr_burst_addr;
  logic [7:0]            wr_burst_len;
  logic                  wr_burst_data_req;
  logic [DATA_WIDTH-1:0] wr_burst_data;
  logic                  wr_burst_finish;

  // Read channel
  logic                  rd_burst_req;
  logic [ADDR_WIDTH-1:0] rd_burst_addr;
  logic [7:0]            rd_burst_len;
  logic                  rd_burst_data_valid;
  logic [DATA_WIDTH-1:0] rd_burst_data;
  logic                  rd_burst_finish;

  // Traffic source side (issues requests, supplies write data)
  modport master (
    output wr_burst_req, wr_burst_addr, wr_burst_len, wr_burst_data,
    input  wr_burst_data_req, wr_burst_finish,
    output rd_burst_req, rd_burst_addr, rd_burst_len,
    input  rd_burst_data_valid, rd_burst_data, rd_burst_finish
  );

  // Controller side (accepts requests, returns read data)
  modport slave (
    input  wr_burst_req, wr_burst_addr, wr_burst_len, wr_burst_data,
    output wr_burst_data_req, wr_burst_finish,
    input  rd_burst_req, rd_burst_addr, rd_burst_len,
    output rd_burst_data_valid, rd_burst_data, rd_burst_finish
  );
endinterface
`default_nettype wire

// File: rtl/ddr2_test_gen.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_test_gen
// Description : Self-checking DDR2 traffic generator. After controller init,
//               writes NUM_BURSTS bursts of an incrementing pattern, reads the
//               region back, checks every beat and drives status LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr2_test_gen #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8,
  parameter int NUM_BURSTS = 16,
  parameter int WR_DELAY   = 100,
  parameter int RD_DELAY   = 200
) (
  input  wire          sys_clk,
  input  wire          sys_rst_n,
  input  wire          init_end,
  ddr2_burst_if.master bus,
  output logic         init_end_led,
  output logic         wr_over_led,
  output logic         rd_error_led
);

  // Derived widths and constants
  localparam int c_max_delay = (WR_DELAY > RD_DELAY) ? WR_DELAY : RD_DELAY;
  localparam int c_dly_w     = (c_max_delay < 1) ? 1 : $clog2(c_max_delay + 1);
  localparam int c_idx_w     = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int c_beat_w    = $clog2(BURST_LEN + 2);

  localparam logic [c_dly_w-1:0]  c_wr_last   = c_dly_w'(WR_DELAY);
  localparam logic [c_dly_w-1:0]  c_rd_last   = c_dly_w'(RD_DELAY);
  localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(NUM_BURSTS - 1);
  localparam logic [c_beat_w:0]   c_beat_len  = (c_beat_w + 1)'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_WAIT = 3'd1,
    S_WR_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RD_REQ  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [c_dly_w-1:0]    r_dly_cnt;
  logic [c_idx_w-1:0]    r_burst_idx;
  logic [DATA_WIDTH-1:0] r_wr_pat;
  logic [DATA_WIDTH-1:0] r_rd_expect;
  logic [c_beat_w-1:0]   r_beat_cnt;

  logic                  w_wr_done;
  logic                  w_rd_done;
  logic                  w_last_burst;
  logic                  w_wr_beat;
  logic                  w_rd_beat;
  logic [c_beat_w:0]     w_beat_total;
  logic                  w_data_bad;
  logic                  w_len_bad;
  logic [ADDR_WIDTH-1:0] w_burst_addr;

  // Strobes only count inside the state that owns them; elsewhere they are ignored.
  assign w_wr_done    = (r_state == S_WR_REQ) && bus.wr_burst_finish;
  assign w_rd_done    = (r_state == S_RD_REQ) && bus.rd_burst_finish;
  assign w_wr_beat    = (r_state == S_WR_REQ) && bus.wr_burst_data_req;
  assign w_rd_beat    = (r_state == S_RD_REQ) && bus.rd_burst_data_valid;
  assign w_last_burst = (r_burst_idx == c_last_idx);

  // Beat total at finish includes a valid beat arriving in the same cycle.
  assign w_beat_total = {1'b0, r_beat_cnt} + (c_beat_w + 1)'(w_rd_beat);
  assign w_data_bad   = w_rd_beat && (bus.rd_burst_data != r_rd_expect);
  assign w_len_bad    = w_rd_done && (w_beat_total != c_beat_len);

  assign w_burst_addr = ADDR_WIDTH'(r_burst_idx) * ADDR_WIDTH'(BURST_LEN);

  // Requests are decoded from the registered state so they drop on the finish edge.
  assign bus.wr_burst_req  = (r_state == S_WR_REQ);
  assign bus.wr_burst_addr = w_burst_addr;
  assign bus.wr_burst_len  = 8'(BURST_LEN);
  assign bus.wr_burst_data = r_wr_pat;
  assign bus.rd_burst_req  = (r_state == S_RD_REQ);
  assign bus.rd_burst_addr = w_burst_addr;
  assign bus.rd_burst_len  = 8'(BURST_LEN);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; a WAIT state lasts DELAY+1 cycles (count 0..DELAY)
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (init_end) begin
          w_next_state = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (r_dly_cnt == c_wr_last) begin
          w_next_state = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (bus.wr_burst_finish) begin
          w_next_state = w_last_burst ? S_RD_WAIT : S_WR_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (r_dly_cnt == c_rd_last) begin
          w_next_state = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (bus.rd_burst_finish) begin
          w_next_state = w_last_burst ? S_DONE : S_RD_WAIT;
        end
      end
      S_DONE: begin
        w_next_state = S_DONE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Inter-burst delay counter: cleared on every state change, counts while waiting
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dly_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_dly_cnt <= '0;
    end else if ((r_state == S_WR_WAIT) || (r_state == S_RD_WAIT)) begin
      r_dly_cnt <= r_dly_cnt + c_dly_w'(1);
    end
  end

  // Burst index shared by the write and read passes; wraps to 0 after the last burst
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_burst_idx <= '0;
    end else if (w_wr_done || w_rd_done) begin
      r_burst_idx <= w_last_burst ? '0 : r_burst_idx + c_idx_w'(1);
    end
  end

  // Write pattern: advances on each consumed beat so the next beat is visible a cycle later
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_pat <= '0;
    end else if (w_wr_beat) begin
      r_wr_pat <= r_wr_pat + DATA_WIDTH'(1);
    end
  end

  // Expected read data tracks the write pattern beat for beat
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rd_expect <= '0;
    end else if (w_rd_beat) begin
      r_rd_expect <= r_rd_expect + DATA_WIDTH'(1);
    end
  end

  // Per-burst read beat counter, saturating so an overlong burst never wraps to a legal count
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_rd_done) begin
      r_beat_cnt <= '0;
    end else if (w_rd_beat && (r_beat_cnt != '1)) begin
      r_beat_cnt <= r_beat_cnt + c_beat_w'(1);
    end
  end

  // Status LEDs: init mirror, sticky write-complete and sticky read-error
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      init_end_led <= 1'b0;
      wr_over_led  <= 1'b0;
      rd_error_led <= 1'b0;
    end else begin
      init_end_led <= init_end;
      if (w_wr_done && w_last_burst) begin
        wr_over_led <= 1'b1;
      end
      if (w_data_bad || w_len_bad) begin
        rd_error_led <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr2_test_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr2_test_gen
// Description : Directed/randomised bench for ddr2_test_gen with a behavioural
//               DDR2 controller model that echoes written data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr2_test_gen;

  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int BL  = 8;
  localparam int NB  = 4;
  localparam int WRD = 6;
  localparam int RDD = 9;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic init_end  = 1'b0;
  logic init_end_led;
  logic wr_over_led;
  logic rd_error_led;

  ddr2_burst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ddr2_test_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL),
    .NUM_BURSTS(NB), .WR_DELAY(WRD), .RD_DELAY(RDD)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .init_end     (init_end),
    .bus          (bus),
    .init_end_led (init_end_led),
    .wr_over_led  (wr_over_led),
    .rd_error_led (rd_error_led)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [DW-1:0] mem [0:NB*BL-1];   // controller model storage
  bit          model_err;           // reference expectation of rd_error_led

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  endtask

  task automatic clear_inputs();
    bus.wr_burst_data_req   = 1'b0;
    bus.wr_burst_finish     = 1'b0;
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_data       = '0;
    bus.rd_burst_finish     = 1'b0;
  endtask

  // Wait for a request to rise, driving junk strobes that must be ignored; checks edge count.
  task automatic wait_rise(input bit rd, input int exp_edges, input string tag);
    int n = 0;
    while (!(rd ? bus.rd_burst_req : bus.wr_burst_req)) begin
      bus.wr_burst_data_req   = 1'($urandom_range(0, 1));
      bus.wr_burst_finish     = 1'($urandom_range(0, 1));
      bus.rd_burst_data_valid = 1'($urandom_range(0, 1));
      bus.rd_burst_data       = $urandom;
      bus.rd_burst_finish     = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (n > 2000) begin
        check({tag, "_timeout"}, 64'(0), 64'(1));
        finish_run();
      end
    end
    clear_inputs();
    check(tag, 64'(n), 64'(exp_edges));
  endtask

  task automatic write_burst(input int b, input bit alternate);
    check("wr_addr", 64'(bus.wr_burst_addr), 64'(b * BL));
    check("wr_data_idle", 64'(bus.wr_burst_data), 64'(b * BL));
    for (int k = 0; k < BL; k++) begin
      int gaps = alternate ? 1 : int'($urandom_range(0, 2));
      repeat (gaps) begin
        bus.wr_burst_data_req = 1'b0;
        tick();
      end
      bus.wr_burst_data_req = 1'b1;
      check("wr_beat", 64'(bus.wr_burst_data), 64'(b * BL + k));
      check("wr_req_held", 64'(bus.wr_burst_req), 64'(1));
      mem[b * BL + k] = bus.wr_burst_data;
      tick();
    end
    bus.wr_burst_data_req = 1'b0;
    if (b == NB - 1) check("wr_over_pre", 64'(wr_over_led), 64'(0));
    bus.wr_burst_finish = 1'b1;
    tick();
    bus.wr_burst_finish = 1'b0;
    check("wr_req_drop", 64'(bus.wr_burst_req), 64'(0));
    check("wr_over_led", 64'(wr_over_led), 64'(b == NB - 1));
  endtask

  task automatic read_burst(input int b, input int corrupt_k, input int nbeats,
                            input int reset_at, output bit aborted);
    bit merged = 1'b0;
    aborted = 1'b0;
    check("rd_addr", 64'(bus.rd_burst_addr), 64'(b * BL));
    for (int k = 0; k < nbeats; k++) begin
      logic [DW-1:0] d;
      repeat ($urandom_range(0, 2)) begin
        bus.rd_burst_data_valid = 1'b0;
        bus.rd_burst_data       = $urandom;
        tick();
      end
      if (k == reset_at) begin
        sys_rst_n = 1'b0;
        clear_inputs();
        #1;
        check("rst_wr_req",  64'(bus.wr_burst_req),  64'(0));
        check("rst_rd_req",  64'(bus.rd_burst_req),  64'(0));
        check("rst_wr_addr", 64'(bus.wr_burst_addr), 64'(0));
        check("rst_rd_addr", 64'(bus.rd_burst_addr), 64'(0));
        check("rst_wr_data", 64'(bus.wr_burst_data), 64'(0));
        check("rst_leds", 64'({init_end_led, wr_over_led, rd_error_led}), 64'(0));
        aborted = 1'b1;
        return;
      end
      d = mem[b * BL + k];
      if (k == corrupt_k) d = d ^ 32'h1;
      if (d !== 32'(b * BL + k)) model_err = 1'b1;
      bus.rd_burst_data_valid = 1'b1;
      bus.rd_burst_data       = d;
      if ((k == nbeats - 1) && ($urandom_range(0, 1) == 1)) begin
        merged = 1'b1;
      end else begin
        tick();
        check("rd_err_beat", 64'(rd_error_led), 64'(model_err));
      end
    end
    if (!merged) begin
      bus.rd_burst_data_valid = 1'b0;
      repeat ($urandom_range(0, 1)) tick();
    end
    if (nbeats != BL) model_err = 1'b1;
    bus.rd_burst_finish = 1'b1;
    tick();
    clear_inputs();
    check("rd_err_finish", 64'(rd_error_led), 64'(model_err));
    check("rd_req_drop", 64'(bus.rd_burst_req), 64'(0));
  endtask

  task automatic run_pass(input int corrupt_b, input int corrupt_k,
                          input int short_b, input int reset_b);
    bit aborted;
    model_err = 1'b0;
    sys_rst_n = 1'b0;
    init_end  = 1'b0;
    clear_inputs();
    repeat (3) tick();
    check("reset_wr_req",  64'(bus.wr_burst_req),  64'(0));
    check("reset_rd_req",  64'(bus.rd_burst_req),  64'(0));
    check("reset_wr_addr", 64'(bus.wr_burst_addr), 64'(0));
    check("reset_wr_data", 64'(bus.wr_burst_data), 64'(0));
    check("reset_lens", 64'({bus.wr_burst_len, bus.rd_burst_len}), 64'({8'(BL), 8'(BL)}));
    check("reset_leds", 64'({init_end_led, wr_over_led, rd_error_led}), 64'(0));
    sys_rst_n = 1'b1;
    repeat (3) tick();
    check("idle_no_req", 64'(bus.wr_burst_req), 64'(0));
    init_end = 1'b1;
    check("init_led_pre", 64'(init_end_led), 64'(0));
    tick();
    check("init_led_lag", 64'(init_end_led), 64'(1));

    for (int b = 0; b < NB; b++) begin
      wait_rise(1'b0, WRD + 1, "wr_req_delay");
      write_burst(b, b == 0);
      if (b == 1) init_end = 1'b0;   // a dropped init_end must not disturb the sequence
    end
    for (int b = 0; b < NB; b++) begin
      wait_rise(1'b1, RDD + 1, "rd_req_delay");
      read_burst(b, (b == corrupt_b) ? corrupt_k : -1, (b == short_b) ? BL - 1 : BL,
                 (b == reset_b) ? 3 : -1, aborted);
      if (aborted) begin
        tick();
        return;
      end
    end

    // DONE: stray strobes are ignored and the LEDs hold
    for (int i = 0; i < 6; i++) begin
      bus.wr_burst_data_req   = 1'($urandom_range(0, 1));
      bus.wr_burst_finish     = 1'($urandom_range(0, 1));
      bus.rd_burst_data_valid = 1'($urandom_range(0, 1));
      bus.rd_burst_data       = $urandom;
      bus.rd_burst_finish     = 1'($urandom_range(0, 1));
      tick();
      check("done_reqs", 64'({bus.wr_burst_req, bus.rd_burst_req}), 64'(0));
    end
    clear_inputs();
    check("done_wr_data", 64'(bus.wr_burst_data), 64'(NB * BL));
    check("done_leds", 64'({init_end_led, wr_over_led, rd_error_led}),
          64'({1'b0, 1'b1, model_err}));
  endtask

  initial begin
    clear_inputs();
    run_pass(-1, -1, -1, -1);   // clean pass
    run_pass( 2,  5, -1, -1);   // beat 5 of read burst 2 returns 20 instead of 21
    run_pass(-1, -1,  1, -1);   // read burst 1 returns only 7 beats
    run_pass(-1, -1, -1,  1);   // reset asserted during read burst 1
    run_pass(-1, -1, -1, -1);   // full restart after mid-read reset
    finish_run();
  end

endmodule
`default_nettype wire
